// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter.
//
// Holds the FSM state encoding and the default widths used by
// dmem_port_arbiter and anything that instantiates it.
package dmem_port_arbiter_pkg;

    // FSM state encoding (kept as plain constants so older code that
    // compares against literal 0/1 keeps working)
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DEFER = 1'b1;

    // Default widths
    localparam int DEF_ADDR_W = 10;  // data-memory word-address width
    localparam int DEF_DATA_W = 32;  // data width
    localparam int DEF_CNT_W  = 16;  // conflict-counter width

endpackage

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter for a dual-issue pipeline.
//
// Two MEM-stage slots share a dual-port data memory. Slot 1 owns port A and
// slot 2 owns port B. When both slots touch the same word and at least one of
// them writes, slot 2 (the younger instruction) is deferred by one cycle and
// the pipeline is stalled for that cycle. This preserves program order: a
// slot-1 load sees the old data, a slot-2 load sees the slot-1 store, and a
// slot-2 store lands last.
//
// Ports:
//   clk                        sole clock, rising edge
//   rst                        asynchronous reset, active low
//   req1_valid/we/addr/wdata   slot-1 access
//   req2_valid/we/addr/wdata   slot-2 access (younger)
//   q_a, q_b                   memory read data for port A / port B
//   port_a_*, port_b_*         memory port address, write data, write enable
//   rdata1, rdata2             load results returned to the slots
//   stall                      freezes PC and pipeline registers for one cycle
//   conflict_cnt               saturating count of serialized bundles
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req2_valid,
    input  logic              req2_we,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [DATA_W-1:0] req2_wdata,
    input  logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] q_b,
    output logic [ADDR_W-1:0] port_a_addr,
    output logic [DATA_W-1:0] port_a_wdata,
    output logic              port_a_we,
    output logic [ADDR_W-1:0] port_b_addr,
    output logic [DATA_W-1:0] port_b_wdata,
    output logic              port_b_we,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              stall,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]        state_reg;
    logic [DATA_W-1:0] hold_reg;        // slot-1 read data captured at the conflict
    logic [ADDR_W-1:0] def_addr_reg;    // deferred slot-2 request
    logic [DATA_W-1:0] def_wdata_reg;
    logic              def_we_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic in_idle;
    logic conflict;

    assign in_idle = (state_reg == ST_IDLE);

    // Only evaluated in IDLE, so the replayed slot-2 access in DEFER can never
    // trigger a second deferral. Masked while reset is held so the arbiter
    // reports no stall during reset.
    assign conflict = rst & in_idle & req1_valid & req2_valid
                    & (req1_addr == req2_addr) & (req1_we | req2_we);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            hold_reg      <= '0;
            def_addr_reg  <= '0;
            def_wdata_reg <= '0;
            def_we_reg    <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (conflict) begin
                        state_reg     <= ST_DEFER;
                        // q_a still reflects memory before the slot-1 store
                        hold_reg      <= q_a;
                        def_addr_reg  <= req2_addr;
                        def_wdata_reg <= req2_wdata;
                        def_we_reg    <= req2_we;
                        if (cnt_reg != CNT_MAX) begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    def_we_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        port_a_addr  = req1_addr;
        port_a_wdata = req1_wdata;
        port_a_we    = req1_valid & req1_we;
        port_b_addr  = req2_addr;
        port_b_wdata = req2_wdata;
        port_b_we    = req2_valid & req2_we;
        rdata1       = q_a;
        rdata2       = q_b;
        stall        = 1'b0;
        if (!in_idle) begin
            // Replay slot 2 on port B; slot 1 already completed last cycle
            port_a_we    = 1'b0;
            port_b_addr  = def_addr_reg;
            port_b_wdata = def_wdata_reg;
            port_b_we    = def_we_reg;
            rdata1       = hold_reg;
        end else if (conflict) begin
            port_b_we = 1'b0;
            stall     = 1'b1;
        end
    end

    assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          req1_valid, req1_we, req2_valid, req2_we;
    logic [AW-1:0] req1_addr, req2_addr;
    logic [DW-1:0] req1_wdata, req2_wdata;

    logic [DW-1:0] q_a, q_b, q_a2, q_b2;
    logic [AW-1:0] port_a_addr, port_b_addr, port_a_addr2, port_b_addr2;
    logic [DW-1:0] port_a_wdata, port_b_wdata, port_a_wdata2, port_b_wdata2;
    logic          port_a_we, port_b_we, port_a_we2, port_b_we2;
    logic [DW-1:0] rdata1, rdata2, rdata1_2, rdata2_2;
    logic          stall, stall2;
    logic [CW-1:0] conflict_cnt;
    logic [1:0]    conflict_cnt2;

    int tests_run;
    int tests_failed;

    // Environment memories: asynchronous read, synchronous write
    logic [DW-1:0] mem  [0:15];
    logic [DW-1:0] mem2 [0:15];
    // Reference model memory
    logic [DW-1:0] ref_mem [0:15];
    int            ref_cnt;

    assign q_a  = mem[port_a_addr[3:0]];
    assign q_b  = mem[port_b_addr[3:0]];
    assign q_a2 = mem2[port_a_addr2[3:0]];
    assign q_b2 = mem2[port_b_addr2[3:0]];

    always @(posedge clk) begin
        if (port_a_we) mem[port_a_addr[3:0]] <= port_a_wdata;
        if (port_b_we) mem[port_b_addr[3:0]] <= port_b_wdata;
        if (port_a_we2) mem2[port_a_addr2[3:0]] <= port_a_wdata2;
        if (port_b_we2) mem2[port_b_addr2[3:0]] <= port_b_wdata2;
    end

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req2_valid(req2_valid), .req2_we(req2_we), .req2_addr(req2_addr), .req2_wdata(req2_wdata),
        .q_a(q_a), .q_b(q_b),
        .port_a_addr(port_a_addr), .port_a_wdata(port_a_wdata), .port_a_we(port_a_we),
        .port_b_addr(port_b_addr), .port_b_wdata(port_b_wdata), .port_b_we(port_b_we),
        .rdata1(rdata1), .rdata2(rdata2), .stall(stall), .conflict_cnt(conflict_cnt)
    );

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req2_valid(req2_valid), .req2_we(req2_we), .req2_addr(req2_addr), .req2_wdata(req2_wdata),
        .q_a(q_a2), .q_b(q_b2),
        .port_a_addr(port_a_addr2), .port_a_wdata(port_a_wdata2), .port_a_we(port_a_we2),
        .port_b_addr(port_b_addr2), .port_b_wdata(port_b_wdata2), .port_b_we(port_b_we2),
        .rdata1(rdata1_2), .rdata2(rdata2_2), .stall(stall2), .conflict_cnt(conflict_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        req2_valid = 0; req2_we = 0; req2_addr = '0; req2_wdata = '0;
    endtask

    // Presents one bundle (called #1 after a rising edge) and waits until it
    // retires. Returns the load data seen on the retiring cycle and the
    // number of stall cycles.
    task automatic run_bundle(input logic v1, input logic w1, input int a1, input logic [DW-1:0] d1,
                              input logic v2, input logic w2, input int a2, input logic [DW-1:0] d2,
                              output logic [DW-1:0] r1, output logic [DW-1:0] r2, output int nstall);
        bit done;
        req1_valid = v1; req1_we = w1; req1_addr = AW'(a1); req1_wdata = d1;
        req2_valid = v2; req2_we = w2; req2_addr = AW'(a2); req2_wdata = d2;
        nstall = 0; r1 = '0; r2 = '0; done = 0;
        for (int i = 0; i < 4 && !done; i++) begin
            @(negedge clk);
            if (stall) begin
                nstall++;
            end else begin
                r1 = rdata1; r2 = rdata2; done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL bundle_timeout: stall never released after %0d cycles, required release", nstall);
        end
        idle_inputs();
    endtask

    // Reference: executes a bundle in program order
    task automatic model_bundle(input logic v1, input logic w1, input int a1, input logic [DW-1:0] d1,
                                input logic v2, input logic w2, input int a2, input logic [DW-1:0] d2,
                                output logic [DW-1:0] e1, output logic [DW-1:0] e2, output int estall);
        bit c;
        logic [DW-1:0] old2;
        c = v1 && v2 && (a1 == a2) && (w1 || w2);
        old2 = ref_mem[a2];
        e1 = ref_mem[a1];
        if (v1 && w1) ref_mem[a1] = d1;
        e2 = c ? ref_mem[a2] : old2;
        if (v2 && w2) ref_mem[a2] = d2;
        estall = c ? 1 : 0;
        if (c) ref_cnt++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        tests_run++;
        if (conflict_cnt !== '0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt); end
        tests_run++;
        if (port_b_we !== 1'b0) begin tests_failed++; $display("FAIL reset_port_b_we: got %0b expected 0", port_b_we); end
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        $display("[TB] reset done");
    endtask

    task automatic test_no_conflict();
        req1_valid = 1; req1_we = 1; req1_addr = 5; req1_wdata = 32'h11;
        req2_valid = 1; req2_we = 1; req2_addr = 7; req2_wdata = 32'h22;
        @(negedge clk);
        tests_run++;
        if ({port_a_we, port_b_we, stall} !== 3'b110) begin
            tests_failed++; $display("FAIL nc_ports: got a_we=%0b b_we=%0b stall=%0b expected 1 1 0", port_a_we, port_b_we, stall);
        end
        @(posedge clk); #1;
        idle_inputs();
        tests_run++;
        if (mem[5] !== 32'h11 || mem[7] !== 32'h22) begin
            tests_failed++; $display("FAIL nc_mem: got %0h %0h expected 11 22", mem[5], mem[7]);
        end
        tests_run++;
        if (conflict_cnt !== 0) begin tests_failed++; $display("FAIL nc_cnt: got %0d expected 0", conflict_cnt); end
        $display("[TB] no_conflict SW 0x11@5 SW 0x22@7");
    endtask

    task automatic test_ww_conflict();
        req1_valid = 1; req1_we = 1; req1_addr = 5; req1_wdata = 32'hAA;
        req2_valid = 1; req2_we = 1; req2_addr = 5; req2_wdata = 32'hBB;
        @(negedge clk);
        tests_run++;
        if ({port_a_we, port_b_we, stall} !== 3'b101) begin
            tests_failed++; $display("FAIL ww_cycle0: got a_we=%0b b_we=%0b stall=%0b expected 1 0 1", port_a_we, port_b_we, stall);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if ({port_a_we, port_b_we, stall} !== 3'b010 || port_b_wdata !== 32'hBB || port_b_addr !== 5) begin
            tests_failed++; $display("FAIL ww_cycle1: got a_we=%0b b_we=%0b stall=%0b wdata=%0h addr=%0d expected 0 1 0 bb 5",
                                     port_a_we, port_b_we, stall, port_b_wdata, port_b_addr);
        end
        @(posedge clk); #1;
        idle_inputs();
        tests_run++;
        if (mem[5] !== 32'hBB) begin tests_failed++; $display("FAIL ww_mem: got %0h expected bb", mem[5]); end
        tests_run++;
        if (conflict_cnt !== 1) begin tests_failed++; $display("FAIL ww_cnt: got %0d expected 1", conflict_cnt); end
        $display("[TB] ww_conflict SW 0xAA@5 SW 0xBB@5");
    endtask

    task automatic test_w1_r2();
        logic [DW-1:0] r1, r2; int ns;
        run_bundle(1, 1, 9, 32'h1, 0, 0, 0, 0, r1, r2, ns);
        run_bundle(1, 1, 9, 32'h2, 1, 0, 9, 0, r1, r2, ns);
        tests_run++;
        if (r2 !== 32'h2) begin tests_failed++; $display("FAIL w1r2_rdata2: got %0h expected 2", r2); end
        tests_run++;
        if (ns !== 1) begin tests_failed++; $display("FAIL w1r2_stall: got %0d expected 1", ns); end
        tests_run++;
        if (conflict_cnt !== 2) begin tests_failed++; $display("FAIL w1r2_cnt: got %0d expected 2", conflict_cnt); end
        $display("[TB] w1_r2 SW 0x2@9 LW @9 rdata2=%0h stalls=%0d", r2, ns);
    endtask

    task automatic test_r1_w2();
        logic [DW-1:0] r1, r2; int ns;
        run_bundle(1, 1, 3, 32'h7, 0, 0, 0, 0, r1, r2, ns);
        run_bundle(1, 0, 3, 0, 1, 1, 3, 32'h8, r1, r2, ns);
        tests_run++;
        if (r1 !== 32'h7) begin tests_failed++; $display("FAIL r1w2_rdata1: got %0h expected 7", r1); end
        tests_run++;
        if (mem[3] !== 32'h8) begin tests_failed++; $display("FAIL r1w2_mem: got %0h expected 8", mem[3]); end
        tests_run++;
        if (ns !== 1) begin tests_failed++; $display("FAIL r1w2_stall: got %0d expected 1", ns); end
        $display("[TB] r1_w2 LW @3 SW 0x8@3 rdata1=%0h", r1);
    endtask

    task automatic test_reset_in_defer();
        req1_valid = 1; req1_we = 1; req1_addr = 5; req1_wdata = 32'hA1;
        req2_valid = 1; req2_we = 1; req2_addr = 5; req2_wdata = 32'hB2;
        @(posedge clk); #1;           // now in DEFER
        rst = 0;
        idle_inputs();
        #1;
        tests_run++;
        if ({port_b_we, stall} !== 2'b00 || conflict_cnt !== 0) begin
            tests_failed++; $display("FAIL rst_defer: got b_we=%0b stall=%0b cnt=%0d expected 0 0 0", port_b_we, stall, conflict_cnt);
        end
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk); #1;
        tests_run++;
        if (mem[5] !== 32'hA1) begin tests_failed++; $display("FAIL rst_defer_mem: got %0h expected a1", mem[5]); end
        $display("[TB] reset_in_defer mem[5]=%0h", mem[5]);
    endtask

    task automatic test_back_to_back_saturation();
        logic [DW-1:0] r1, r2; int ns;
        for (int i = 0; i < 5; i++) begin
            run_bundle(1, 1, 2, DW'(i), 1, 1, 2, DW'(i + 100), r1, r2, ns);
            tests_run++;
            if (ns !== 1) begin tests_failed++; $display("FAIL b2b_stall[%0d]: got %0d expected 1", i, ns); end
            $display("[TB] back_to_back %0d cnt_sat=%0d", i, conflict_cnt2);
        end
        tests_run++;
        if (conflict_cnt2 !== 2'd3) begin tests_failed++; $display("FAIL sat_cnt: got %0d expected 3", conflict_cnt2); end
        tests_run++;
        if (conflict_cnt !== 5) begin tests_failed++; $display("FAIL b2b_cnt: got %0d expected 5", conflict_cnt); end
        run_bundle(1, 0, 2, 0, 1, 0, 2, 0, r1, r2, ns);
        tests_run++;
        if (ns !== 0 || r1 !== 32'd104 || r2 !== 32'd104) begin
            tests_failed++; $display("FAIL rr_same: got stalls=%0d r1=%0h r2=%0h expected 0 68 68", ns, r1, r2);
        end
        tests_run++;
        if (conflict_cnt2 !== 2'd3) begin tests_failed++; $display("FAIL rr_sat_cnt: got %0d expected 3", conflict_cnt2); end
        $display("[TB] read_read same addr stalls=%0d", ns);
    endtask

    task automatic test_random();
        logic [DW-1:0] r1, r2, e1, e2, d1, d2; int ns, es, a1, a2; logic v1, w1, v2, w2;
        int base_cnt;
        base_cnt = int'(conflict_cnt);
        ref_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            d1 = $urandom; d2 = $urandom;
            run_bundle(1, 1, 2 * i, d1, 1, 1, 2 * i + 1, d2, r1, r2, ns);
            ref_mem[2 * i] = d1; ref_mem[2 * i + 1] = d2;
        end
        for (int n = 0; n < 200; n++) begin
            v1 = ($urandom_range(0, 3) != 0); w1 = $urandom_range(0, 1) == 1;
            v2 = ($urandom_range(0, 3) != 0); w2 = $urandom_range(0, 1) == 1;
            a1 = $urandom_range(0, 3); a2 = $urandom_range(0, 3);
            d1 = $urandom; d2 = $urandom;
            model_bundle(v1, w1, a1, d1, v2, w2, a2, d2, e1, e2, es);
            run_bundle(v1, w1, a1, d1, v2, w2, a2, d2, r1, r2, ns);
            tests_run++;
            if (ns !== es) begin tests_failed++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", n, ns, es); end
            if (v1 && !w1) begin
                tests_run++;
                if (r1 !== e1) begin tests_failed++; $display("FAIL rnd_rdata1[%0d]: got %0h expected %0h", n, r1, e1); end
            end
            if (v2 && !w2) begin
                tests_run++;
                if (r2 !== e2) begin tests_failed++; $display("FAIL rnd_rdata2[%0d]: got %0h expected %0h", n, r2, e2); end
            end
            $display("[TB] rnd %0d s1 v=%0b we=%0b @%0d s2 v=%0b we=%0b @%0d stalls=%0d", n, v1, w1, a1, v2, w2, a2, ns);
        end
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (mem[k] !== ref_mem[k]) begin tests_failed++; $display("FAIL rnd_mem[%0d]: got %0h expected %0h", k, mem[k], ref_mem[k]); end
        end
        tests_run++;
        if (int'(conflict_cnt) !== base_cnt + ref_cnt) begin
            tests_failed++; $display("FAIL rnd_cnt: got %0d expected %0d", conflict_cnt, base_cnt + ref_cnt);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        ref_cnt = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_no_conflict();
        test_ww_conflict();
        test_w1_r2();
        test_r1_w2();
        test_reset_in_defer();
        test_back_to_back_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
